// File: rtl/sd_pkg.sv
// Shared types for the sd detector, its result packer and their benches.
package sd_pkg;

  localparam int SD_FRAME_LEN = 14;

  function automatic int sd_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int SD_CNT_W = sd_cnt_w(SD_FRAME_LEN);

  typedef struct packed {
    logic [SD_FRAME_LEN-1:0] frame;
    logic [SD_CNT_W-1:0]     hits;
    logic                    is_short;
  } sd_frame_t;

endpackage

// File: rtl/sd_fifo2.sv
// Two-entry FIFO; head is read straight from storage, so outputs depend only on flops.
// A push while full is accepted only if the head pops in the same cycle, otherwise it is ignored.
module sd_fifo2
  import sd_pkg::*;
#(
  parameter type T = sd_frame_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_dat,
  output logic full,
  input  logic pop,
  output logic head_vld,
  output T     head_dat
);

  T           mem_q [2];
  T           mem_d [2];
  logic       rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_pop, do_push, wr_ptr;

  assign head_vld = (cnt_q != 2'd0);
  assign full     = (cnt_q == 2'd2);
  assign head_dat = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    do_pop  = pop && head_vld;
    do_push = push && (!full || do_pop);
    // With two slots, the write slot is the head when count is 0 or 2, else the other one.
    wr_ptr  = rd_q ^ cnt_q[0];
    if (do_push) begin
      mem_d[wr_ptr] = push_dat;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_result_pack.sv
// Packs the serial detector stream into FRAME_LEN-bit frames with a hit count,
// buffered in a two-entry valid/ready queue; frame_done flushes a partial frame.
module sd_result_pack
  import sd_pkg::*;
#(
  parameter int FRAME_LEN = SD_FRAME_LEN,
  parameter int CNT_W     = sd_cnt_w(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 frame_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAME_LEN-1:0] out_frame,
  output logic [CNT_W-1:0]     out_hits,
  output logic                 out_short,
  output logic                 overflow
);

  localparam int IDX_W = $clog2(FRAME_LEN);

  typedef struct packed {
    logic [FRAME_LEN-1:0] frame;
    logic [CNT_W-1:0]     hits;
    logic                 is_short;
  } frame_t;

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRAME_LEN-1:0] acc_q, acc_d, acc_n;
  logic [CNT_W-1:0]     hits_q, hits_d, hits_n;
  logic                 overflow_q, overflow_d;
  logic                 last_bit, close, pop, fifo_full, head_vld;
  frame_t               push_dat, head_dat;

  always_comb begin
    acc_n = acc_q;
    if (bit_valid) begin
      acc_n[idx_q] = bit_in;
    end
    hits_n   = hits_q + CNT_W'(bit_valid & bit_in);
    last_bit = bit_valid && (idx_q == IDX_W'(FRAME_LEN - 1));
    // A bit arriving with frame_done counts as held, so it is flushed with the frame.
    close    = last_bit || (frame_done && (bit_valid || (idx_q != '0)));

    push_dat.frame    = acc_n;
    push_dat.hits     = hits_n;
    push_dat.is_short = !last_bit;

    pop        = head_vld && out_ready;
    overflow_d = overflow_q | (close & fifo_full & !pop);

    if (close) begin
      idx_d  = '0;
      acc_d  = '0;
      hits_d = '0;
    end else begin
      idx_d  = idx_q + IDX_W'(bit_valid);
      acc_d  = acc_n;
      hits_d = hits_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      acc_q      <= '0;
      hits_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      hits_q     <= hits_d;
      overflow_q <= overflow_d;
    end
  end

  sd_fifo2 #(
    .T (frame_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (close),
    .push_dat (push_dat),
    .full     (fifo_full),
    .pop      (pop),
    .head_vld (head_vld),
    .head_dat (head_dat)
  );

  assign out_valid = head_vld;
  assign out_frame = head_dat.frame;
  assign out_hits  = head_dat.hits;
  assign out_short = head_dat.is_short;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sd_result_pack.sv
// Directed bench for sd_result_pack with a queue-based frame model checked every cycle.
module tb_sd_result_pack;
  import sd_pkg::*;

  localparam int FL = SD_FRAME_LEN;
  localparam int CW = sd_cnt_w(FL);

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_valid, bit_in, frame_done, out_ready;
  logic          out_valid, out_short, overflow;
  logic [FL-1:0] out_frame;
  logic [CW-1:0] out_hits;

  always #5 clk = ~clk;

  sd_result_pack dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .frame_done (frame_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_frame  (out_frame),
    .out_hits   (out_hits),
    .out_short  (out_short),
    .overflow   (overflow)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] frame;
    int          hits;
    bit          shrt;
  } exp_t;

  exp_t      mq[$];
  bit        m_cur[$];
  bit        m_ovf;
  sd_frame_t seen[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bits collected as a list, frame closed by length or done, queue capped at two.
  always @(negedge rst) begin
    mq.delete();
    m_cur.delete();
    m_ovf = 1'b0;
  end

  always @(posedge clk) begin : model_upd
    bit   pop_m, close_m;
    exp_t e;
    if (rst === 1'b1) begin
      pop_m = (mq.size() > 0) && (out_ready === 1'b1);
      if (bit_valid) m_cur.push_back(bit_in);
      close_m = (m_cur.size() == FL) || (frame_done && m_cur.size() > 0);
      if (pop_m) void'(mq.pop_front());
      if (close_m) begin
        e.frame = 0;
        e.hits  = 0;
        foreach (m_cur[i]) if (m_cur[i]) begin
          e.frame[i] = 1'b1;
          e.hits++;
        end
        e.shrt = (m_cur.size() < FL);
        if (mq.size() < 2) mq.push_back(e);
        else m_ovf = 1'b1;
        m_cur.delete();
      end
    end
  end

  always @(posedge clk) begin : pop_log
    sd_frame_t s;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      s.frame    = out_frame;
      s.hits     = out_hits;
      s.is_short = out_short;
      seen.push_back(s);
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("m_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("m_frame", out_frame, mq[0].frame);
        chk("m_hits", out_hits, mq[0].hits);
        chk("m_short", out_short, mq[0].shrt);
      end
      chk("m_overflow", overflow, m_ovf);
    end
  end

  task automatic cyc(input bit v, input bit b, input bit d);
    bit_valid  = v;
    bit_in     = b;
    frame_done = d;
    @(negedge clk);
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic send_frame(input logic [FL-1:0] w, input bit done_last);
    for (int i = 0; i < FL; i++) cyc(1'b1, w[i], done_last && (i == FL - 1));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FL-1:0] w;
    int            base;
    bit            pat1 [FL] = '{0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0};
    bit            pat2 [5]  = '{1, 1, 0, 1, 1};

    rst        = 1'b0;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    frame_done = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_frame", out_frame, 0);
    chk("rst_hits", out_hits, 0);
    chk("rst_short", out_short, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single full frame, first bit lands in bit 0.
    for (int i = 0; i < FL; i++) w[i] = pat1[i];
    send_frame(w, 1'b0);
    chk("single_valid", out_valid, 1);
    chk("single_frame", out_frame, 14'h1164);
    chk("single_hits", out_hits, 5);
    chk("single_short", out_short, 0);
    @(negedge clk);
    chk("single_gone", out_valid, 0);
    chk("single_count", seen.size(), 1);

    // Early flush, then a done with nothing held.
    for (int i = 0; i < 5; i++) cyc(1'b1, pat2[i], 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("flush_valid", out_valid, 1);
    chk("flush_frame", out_frame, 14'h001B);
    chk("flush_hits", out_hits, 4);
    chk("flush_short", out_short, 1);
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("empty_close", seen.size(), 2);

    // Done together with the last bit.
    send_frame('1, 1'b1);
    chk("last_frame", out_frame, 14'h3FFF);
    chk("last_hits", out_hits, 14);
    chk("last_short", out_short, 0);
    repeat (3) @(negedge clk);
    chk("last_count", seen.size(), 3);

    // Backpressure: third frame dropped.
    out_ready = 1'b0;
    send_frame(14'h0001, 1'b0);
    send_frame(14'h0003, 1'b0);
    chk("bp_ovf_before", overflow, 0);
    send_frame(14'h0007, 1'b0);
    chk("bp_ovf_after", overflow, 1);
    chk("bp_head1", out_hits, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head2", out_hits, 2);
    @(negedge clk);
    chk("bp_empty", out_valid, 0);
    chk("bp_ovf_sticky", overflow, 1);
    chk("bp_count", seen.size(), 5);
    chk("bp_pop1", seen[3].hits, 1);
    chk("bp_pop2", seen[4].hits, 2);

    // Push with pop while full.
    do_reset();
    base      = seen.size();
    out_ready = 1'b0;
    send_frame(14'h000F, 1'b0);
    send_frame(14'h001F, 1'b0);
    for (int i = 0; i < FL - 1; i++) cyc(1'b1, i < 6, 1'b0);
    out_ready = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("pp_overflow", overflow, 0);
    chk("pp_count", seen.size() - base, 3);
    chk("pp_order1", seen[base].hits, 4);
    chk("pp_order2", seen[base + 1].hits, 5);
    chk("pp_order3", seen[base + 2].hits, 6);
    chk("pp_frame3", seen[base + 2].frame, 14'h003F);

    // Asynchronous reset mid-frame with one frame buffered.
    out_ready = 1'b0;
    send_frame(14'h0101, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_frame", out_frame, 0);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    base      = seen.size();
    send_frame(14'h1555, 1'b0);
    chk("arst_new_valid", out_valid, 1);
    chk("arst_new_frame", out_frame, 14'h1555);
    chk("arst_new_hits", out_hits, 7);
    chk("arst_new_short", out_short, 0);
    chk("arst_new_ovf", overflow, 0);
    @(negedge clk);
    chk("arst_count", seen.size() - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
